// File: rtl/rd_req_tagger_if.sv
// rd_req_tagger_if: bundles the host request, memory request, reorder-table
// write, completion and credit signals of the read-request tagger.
//   slave  modport: the tagger's view (accepts host requests, drives memory).
//   master modport: the surrounding system's view (host, memory, reorder buffer).
// Parameters: ADDR_W (address width), OCC_W (occupancy counter width).
interface rd_req_tagger_if #(
  parameter int ADDR_W = 40,
  parameter int OCC_W  = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [7:0]        mem_req_len;
  logic [7:0]        mem_req_tag;

  logic              tse_en;
  logic [7:0]        tse_tag;
  logic [31:0]       tse;

  logic              cpl_en;
  logic [7:0]        cpl_tag;
  logic              drain_en;

  logic [8:0]        outstanding;
  logic [OCC_W-1:0]  occupancy;
  logic              err_len;

  modport slave (
    input  req_valid, req_addr, req_len, mem_req_ready, cpl_en, cpl_tag, drain_en,
    output req_ready, mem_req_valid, mem_req_addr, mem_req_len, mem_req_tag,
           tse_en, tse_tag, tse, outstanding, occupancy, err_len
  );

  modport master (
    output req_valid, req_addr, req_len, mem_req_ready, cpl_en, cpl_tag, drain_en,
    input  req_ready, mem_req_valid, mem_req_addr, mem_req_len, mem_req_tag,
           tse_en, tse_tag, tse, outstanding, occupancy, err_len
  );
endinterface

// File: rtl/rd_req_tagger.sv
// rd_req_tagger: upstream stage of the read-data reorder buffer.
// Accepts host read requests, gives each a round-robin 8-bit tag, writes the
// request's cumulative end position (tse) into the reorder per-tag table and
// then issues the tagged request to the memory read port. Buffer-space credits
// and per-tag busy tracking keep the reorder buffer from overrun or tag aliasing.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       req_* host handshake, mem_req_* memory handshake,
//                     tse_en/tse_tag/tse table write, cpl_en/cpl_tag tag
//                     completion, drain_en beat drained, outstanding/occupancy
//                     status, err_len length-rejection pulse
//   stat_issued       (RD_REQ_TAGGER_STATS_EN only) memory handshakes, wraps
//   stat_stall        (RD_REQ_TAGGER_STATS_EN only) WAIT cycles without grant
//
// Optional feature macro: RD_REQ_TAGGER_STATS_EN
module rd_req_tagger #(
  parameter int ADDR_W   = 40,
  parameter int BUF_SIZE = 512,
  parameter int MAX_LEN  = 64,
  parameter int OCC_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  rd_req_tagger_if.slave    bus
`ifdef RD_REQ_TAGGER_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  localparam logic [7:0]     MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [OCC_W:0] BUF_SIZE_W = (OCC_W+1)'(BUF_SIZE);

  logic [1:0]        state;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_len;
  logic [7:0]        next_tag;
  logic [31:0]       wr_pos;
  logic [OCC_W-1:0]  occupancy;
  logic [8:0]        outstanding;
  logic [255:0]      tag_busy;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_len;
  logic [7:0]        mem_tag;
  logic              err_len;

  logic [OCC_W:0]    occ_sum;
  logic              credit_ok;
  logic              grant;
  logic              cpl_hit;
  logic [31:0]       tse_val;
  logic [OCC_W-1:0]  occ_next;
  logic [8:0]        out_next;
  logic [255:0]      busy_next;

  function automatic logic len_ok(input logic [7:0] len);
    return (len != 8'd0) && (len <= MAX_LEN_B);
  endfunction

  // Credit check is done one bit wider than the counter so it cannot wrap.
  assign occ_sum   = {1'b0, occupancy} + (OCC_W+1)'(lat_len);
  assign credit_ok = (occ_sum <= BUF_SIZE_W);
  // Tags are handed out strictly in order: a busy next_tag stalls, never skips.
  assign grant     = (state == S_WAIT) && !tag_busy[next_tag] && credit_ok;
  assign cpl_hit   = bus.cpl_en && tag_busy[bus.cpl_tag];
  assign tse_val   = wr_pos + 32'(lat_len);

  always_comb begin
    occ_next = occupancy;
    if (grant)
      occ_next = occ_sum[OCC_W-1:0];
    // Drain saturates at zero; with a grant the sum is at least 1.
    if (bus.drain_en && (occ_next != '0))
      occ_next = occ_next - 1'b1;
  end

  always_comb begin
    out_next = outstanding;
    case ({grant, cpl_hit})
      2'b10:   out_next = outstanding + 9'd1;
      2'b01:   out_next = outstanding - 9'd1;
      default: out_next = outstanding;
    endcase
  end

  // A grant never targets a busy tag, so a same-cycle completion is always
  // for a different tag and both updates can apply.
  always_comb begin
    busy_next = tag_busy;
    if (cpl_hit)
      busy_next[bus.cpl_tag] = 1'b0;
    if (grant)
      busy_next[next_tag] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      lat_addr    <= '0;
      lat_len     <= '0;
      next_tag    <= '0;
      wr_pos      <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      tag_busy    <= '0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_len     <= '0;
      mem_tag     <= '0;
      err_len     <= 1'b0;
    end else begin
      err_len     <= 1'b0;
      occupancy   <= occ_next;
      outstanding <= out_next;
      tag_busy    <= busy_next;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (len_ok(bus.req_len)) begin
              lat_addr <= bus.req_addr;
              lat_len  <= bus.req_len;
              state    <= S_WAIT;
            end else begin
              err_len  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (grant) begin
            wr_pos    <= tse_val;
            next_tag  <= next_tag + 8'd1;
            mem_addr  <= lat_addr;
            mem_len   <= lat_len;
            mem_tag   <= next_tag;
            mem_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RD_REQ_TAGGER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (state == S_ISSUE && bus.mem_req_ready)
        stat_issued <= stat_issued + 32'd1;
      if (state == S_WAIT && !grant)
        stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

  // The table write happens in the grant cycle itself, one cycle ahead of
  // mem_req_valid, so the table entry exists before memory sees the tag.
  assign bus.req_ready     = !rst && (state == S_IDLE);
  assign bus.tse_en        = !rst && grant;
  assign bus.tse_tag       = bus.tse_en ? next_tag : 8'd0;
  assign bus.tse           = bus.tse_en ? tse_val : 32'd0;
  assign bus.mem_req_valid = mem_valid;
  assign bus.mem_req_addr  = mem_addr;
  assign bus.mem_req_len   = mem_len;
  assign bus.mem_req_tag   = mem_tag;
  assign bus.outstanding   = outstanding;
  assign bus.occupancy     = occupancy;
  assign bus.err_len       = err_len;

endmodule

// File: doc/rd_req_tagger.md
Name: rd_req_tagger

Overview:
- Upstream stage of the read-data reorder buffer.
- Accepts host read requests, assigns each a round-robin 8-bit tag, and computes the request's cumulative end position in the reorder buffer.
- Writes that end position (tag sequence end) into the reorder buffer's per-tag table, then issues the tagged request to the memory read port.
- Enforces buffer-space credits and tag-reuse safety so the downstream reorder buffer can never be overrun or see an aliased tag.

Parameters:
- ADDR_W, 40, width of the host/memory read address.
- BUF_SIZE, 512, reorder buffer depth in 128-bit beats; must equal the downstream buffer depth.
- MAX_LEN, 64, maximum request length in beats; must be ≤255.
- OCC_W, 10, occupancy counter width; must be ≥ clog2(BUF_SIZE+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  host request accepted when high with req_valid
- req_addr  in  ADDR_W  read start address
- req_len  in  8  beats requested
- mem_req_valid  out  1  tagged request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  forwarded address
- mem_req_len  out  8  forwarded length
- mem_req_tag  out  8  assigned tag
- tse_en  out  1  one-cycle write strobe to the reorder per-tag table
- tse_tag  out  8  tag being written
- tse  out  32  cumulative end position for this tag (modulo 2^32)
- cpl_en  in  1  memory signals final beat returned for cpl_tag
- cpl_tag  in  8  completed tag
- drain_en  in  1  one beat left the reorder buffer output
- outstanding  out  9  tags currently busy (0..256)
- occupancy  out  OCC_W  beats reserved in the reorder buffer
- err_len  out  1  one-cycle pulse when a request is rejected for its length

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=0 during rst, else state-driven.
  - mem_req_valid=0, tse_en=0, err_len=0.
  - tse=0, tse_tag=0, mem_req_* = 0.
  - next_tag=0, wr_pos=0, occupancy=0, outstanding=0, tag_busy[255:0]=0.
- States: IDLE, WAIT, ISSUE.
- IDLE: req_ready=1. On req_valid:
  - If req_len==0 or req_len>MAX_LEN: drop the request, pulse err_len next cycle, stay in IDLE; no tag or credit is consumed.
  - Otherwise latch addr and len, then go to WAIT.
- WAIT: req_ready=0.
  - Grant condition: tag_busy[next_tag]==0 and occupancy + len ≤ BUF_SIZE. Compare at OCC_W+1 bits; no wrap.
  - On grant, in one cycle:
    - tse_en=1, tse_tag=next_tag, tse=wr_pos+len.
    - wr_pos += len, occupancy += len.
    - tag_busy[next_tag]=1, next_tag += 1 (8-bit wrap 255→0).
    - Load mem_req_* and go to ISSUE.
  - No grant: hold in WAIT indefinitely; tags stay strictly in order, no skipping.
- ISSUE: mem_req_valid=1 (first asserted the cycle after tse_en). Fields are stable until mem_req_ready; on the handshake go to IDLE.
- Minimum request-to-request spacing is 3 cycles: IDLE accept, WAIT grant, ISSUE handshake.
- tse is always written ≥1 cycle before the memory sees the request, so the reorder table is valid before any data returns.
- Completion handling:
  - cpl_en clears tag_busy[cpl_tag]; cpl_en for a non-busy tag is ignored.
  - A grant and a completion of different tags in the same cycle both apply.
  - A grant cannot target a busy tag, so same-tag collision is impossible.
- Occupancy and outstanding:
  - drain_en decrements occupancy; occupancy saturates at 0.
  - A grant and drain_en in the same cycle give a net change of +len−1.
  - outstanding = popcount of tag_busy, maintained incrementally (+1 grant, −1 valid completion; both in one cycle gives 0).
- Reset mid-ISSUE or mid-WAIT abandons the request with no memory handshake. All tracking clears; the downstream reorder buffer must be reset together with this block.

Optional Feature:
- Macro: RD_REQ_TAGGER_STATS_EN.
- When defined, adds outputs stat_issued (32-bit, count of mem_req handshakes) and stat_stall (32-bit, cycles spent in WAIT without grant). Both clear on rst and wrap at 2^32.
- When undefined, neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Single request: addr=0x100, len=4 after reset → tse_en with tag 0, tse=4; mem_req_valid the next cycle with tag 0, len 4; occupancy=4, outstanding=1.
- Back-to-back requests of len 4, 8, 16 → tags 0, 1, 2 with tse 4, 12, 28; occupancy=28.
- Credit stall: issue 8 requests of len 64 (occupancy 512), then a len-1 request → held in WAIT, req_ready=0. One drain_en pulse → grant next cycle, tse=513.
- Tag stall: 256 requests of len 1 with drain_en each cycle and no cpl → the 257th request waits on tag 0. cpl_en with tag 0 → grant with tag 0, tse=257.
- Length errors: req_len=0 and req_len=65 → err_len pulse each time, no tse_en, next_tag unchanged.
- Reset while in ISSUE with mem_req_ready=0 → mem_req_valid=0 the cycle after rst, occupancy=0, the next request gets tag 0 and tse=len.
